// File: rtl/line_fetch_sched.sv
// Line-fetch scheduler for the DVI output path: keeps a two-entry ping-pong line buffer
// filled ahead of active video by issuing burst reads, and flags lines that start unfilled.
module line_fetch_sched #(
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned LINE_WORDS = 320,
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned LEN_W      = 6
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          hsync,
  input  logic                          vsync,
  input  logic                          data_en,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ADDR_W-1:0]             req_addr,
  output logic [LEN_W-1:0]              req_len,
  output logic                          req_buf,
  output logic [$clog2(LINE_WORDS)-1:0] req_offset,
  input  logic                          burst_done,
  output logic                          disp_buf,
  output logic [$clog2(V_ACTIVE)-1:0]   line_idx,
  output logic                          underrun
);

  localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W    = $clog2(V_ACTIVE);
  localparam int unsigned WL_W      = $clog2(LINE_WORDS + 1);
  localparam logic [1:0]  QueueInit = (V_ACTIVE > 1) ? 2'b11 : 2'b01;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                      state_q, state_d;
  logic                        vsync_q, vsync_prev_q, de_q, de_prev_q;
  logic [ADDR_W-1:0]           frame_base_q, frame_base_d;
  logic [LINE_W-1:0]           line_idx_q, line_idx_d;
  logic                        disp_buf_q, disp_buf_d;
  logic [1:0]                  buf_full_q, buf_full_d;
  logic                        underrun_q, underrun_d;
  logic                        pending_q, pending_d;
  logic [1:0]                  q_valid_q, q_valid_d;
  logic [1:0][LINE_W-1:0]      q_line_q, q_line_d;
  logic                        fetch_buf_q, fetch_buf_d;
  logic [ADDR_W-1:0]           line_base_q, line_base_d;
  logic [WL_W-1:0]             words_left_q, words_left_d;
  logic [OFF_W-1:0]            offset_q, offset_d;

  logic                        frame_start, line_end, line_start;
  logic [31:0]                 len32;
  logic                        sel_buf;
  logic [WL_W-1:0]             wl_next;
  logic                        unused_hsync;

  assign unused_hsync = hsync;
  assign frame_start  = vsync_q & ~vsync_prev_q;
  assign line_end     = ~de_q & de_prev_q;
  assign line_start   = de_q & ~de_prev_q;

  assign disp_buf = disp_buf_q;
  assign line_idx = line_idx_q;
  assign underrun = underrun_q;

  always_comb begin
    state_d      = state_q;
    frame_base_d = frame_base_q;
    line_idx_d   = line_idx_q;
    disp_buf_d   = disp_buf_q;
    buf_full_d   = buf_full_q;
    underrun_d   = underrun_q;
    pending_d    = pending_q;
    q_valid_d    = q_valid_q;
    q_line_d     = q_line_q;
    fetch_buf_d  = fetch_buf_q;
    line_base_d  = line_base_q;
    words_left_d = words_left_q;
    offset_d     = offset_q;
    wl_next      = words_left_q;

    len32 = (32'(words_left_q) > BURST_LEN) ? BURST_LEN : 32'(words_left_q);

    // Oldest line first; outside a frame restart only the freed buffer is ever queued.
    if (q_valid_q == 2'b11) sel_buf = (q_line_q[1] < q_line_q[0]);
    else                    sel_buf = q_valid_q[1];

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d   = 1'b0;
          q_valid_d   = QueueInit;
          q_line_d[0] = '0;
          q_line_d[1] = LINE_W'(1);
        end else if (|q_valid_q) begin
          fetch_buf_d        = sel_buf;
          q_valid_d[sel_buf] = 1'b0;
          line_base_d  = frame_base_q + ADDR_W'(32'(q_line_q[sel_buf]) * LINE_WORDS);
          words_left_d = WL_W'(LINE_WORDS);
          offset_d     = '0;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (req_ready) state_d = StWait;
      end
      StWait: begin
        if (burst_done) begin
          wl_next      = words_left_q - WL_W'(len32);
          words_left_d = wl_next;
          offset_d     = offset_q + OFF_W'(len32);
          if (wl_next == '0) begin
            if (!pending_q) buf_full_d[fetch_buf_q] = 1'b1;
            state_d = StIdle;
          end else if (pending_q) begin
            // Rest of a superseded line is not worth fetching.
            state_d = StIdle;
          end else begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start) begin
      frame_base_d = base_addr;
      line_idx_d   = '0;
      disp_buf_d   = 1'b0;
      buf_full_d   = 2'b00;
      underrun_d   = 1'b0;
      if (state_d == StIdle) begin
        pending_d   = 1'b0;
        q_valid_d   = QueueInit;
        q_line_d[0] = '0;
        q_line_d[1] = LINE_W'(1);
      end else begin
        pending_d = 1'b1;
        q_valid_d = 2'b00;
      end
    end else begin
      if (line_end) begin
        buf_full_d[disp_buf_q] = 1'b0;
        disp_buf_d             = ~disp_buf_q;
        if (line_idx_q != LINE_W'(V_ACTIVE - 1)) line_idx_d = line_idx_q + LINE_W'(1);
        if (32'(line_idx_q) + 32'd2 < V_ACTIVE) begin
          q_valid_d[disp_buf_q] = 1'b1;
          q_line_d[disp_buf_q]  = line_idx_q + LINE_W'(2);
        end
      end
      if (line_start && !buf_full_q[disp_buf_q]) underrun_d = 1'b1;
    end

    req_valid  = (state_q == StReq);
    req_addr   = req_valid ? line_base_q + ADDR_W'(offset_q) : '0;
    req_len    = req_valid ? LEN_W'(len32) : '0;
    req_buf    = req_valid ? fetch_buf_q : 1'b0;
    req_offset = req_valid ? offset_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      de_q         <= 1'b0;
      de_prev_q    <= 1'b0;
      frame_base_q <= '0;
      line_idx_q   <= '0;
      disp_buf_q   <= 1'b0;
      buf_full_q   <= 2'b00;
      underrun_q   <= 1'b0;
      pending_q    <= 1'b0;
      q_valid_q    <= 2'b00;
      q_line_q     <= '0;
      fetch_buf_q  <= 1'b0;
      line_base_q  <= '0;
      words_left_q <= '0;
      offset_q     <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
      de_q         <= data_en;
      de_prev_q    <= de_q;
      frame_base_q <= frame_base_d;
      line_idx_q   <= line_idx_d;
      disp_buf_q   <= disp_buf_d;
      buf_full_q   <= buf_full_d;
      underrun_q   <= underrun_d;
      pending_q    <= pending_d;
      q_valid_q    <= q_valid_d;
      q_line_q     <= q_line_d;
      fetch_buf_q  <= fetch_buf_d;
      line_base_q  <= line_base_d;
      words_left_q <= words_left_d;
      offset_q     <= offset_d;
    end
  end

endmodule
